// File: rtl/fp_regfile_sb.sv
// FPU register file: 2 async read ports, 2 writeback lanes, per-register busy scoreboard.
// Optional write-to-read forwarding when RF_BYPASS_EN is defined (lane 1 has priority).
module fp_regfile_sb #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 32,
  parameter int INIT_STEP = 100,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [WIDTH-1:0] rd_data_a,
  output logic [WIDTH-1:0] rd_data_b,
  output logic             rd_busy_a,
  output logic             rd_busy_b,
  input  logic             wr_en0,
  input  logic [AW-1:0]    wr_addr0,
  input  logic [WIDTH-1:0] wr_data0,
  input  logic             wr_en1,
  input  logic [AW-1:0]    wr_addr1,
  input  logic [WIDTH-1:0] wr_data1,
  input  logic             rsv_en,
  input  logic [AW-1:0]    rsv_addr,
  output logic             rsv_ok,
  output logic [DEPTH-1:0] busy_vec
);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic             rsv_clear_hit;

  // A reservation racing a same-cycle clear is refused so busy never sees set and clear together.
  assign rsv_clear_hit = (wr_en0 && (wr_addr0 == rsv_addr)) ||
                         (wr_en1 && (wr_addr1 == rsv_addr));
  assign rsv_ok        = rsv_en && !busy[rsv_addr] && !rsv_clear_hit;
  assign busy_vec      = busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= WIDTH'(i * INIT_STEP);
      end
      busy <= '0;
    end else begin
      if (wr_en0) begin
        regs[wr_addr0] <= wr_data0;
        busy[wr_addr0] <= 1'b0;
      end
      if (wr_en1) begin
        regs[wr_addr1] <= wr_data1;
        busy[wr_addr1] <= 1'b0;
      end
      if (rsv_ok) begin
        busy[rsv_addr] <= 1'b1;
      end
    end
  end

  always_comb begin
    rd_data_a = regs[rd_addr_a];
    rd_busy_a = busy[rd_addr_a];
    rd_data_b = regs[rd_addr_b];
    rd_busy_b = busy[rd_addr_b];
`ifdef RF_BYPASS_EN
    if (wr_en0 && (wr_addr0 == rd_addr_a)) begin
      rd_data_a = wr_data0;
      rd_busy_a = 1'b0;
    end
    if (wr_en1 && (wr_addr1 == rd_addr_a)) begin
      rd_data_a = wr_data1;
      rd_busy_a = 1'b0;
    end
    if (wr_en0 && (wr_addr0 == rd_addr_b)) begin
      rd_data_b = wr_data0;
      rd_busy_b = 1'b0;
    end
    if (wr_en1 && (wr_addr1 == rd_addr_b)) begin
      rd_data_b = wr_data1;
      rd_busy_b = 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_fp_regfile_sb.sv
// Directed bench for fp_regfile_sb with default parameters; expectations follow RF_BYPASS_EN.
module tb_fp_regfile_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rd_addr_a, rd_addr_b;
  logic [31:0] rd_data_a, rd_data_b;
  logic        rd_busy_a, rd_busy_b;
  logic        wr_en0, wr_en1;
  logic [4:0]  wr_addr0, wr_addr1;
  logic [31:0] wr_data0, wr_data1;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic        rsv_ok;
  logic [31:0] busy_vec;

  int total = 0;
  int bad   = 0;

  fp_regfile_sb dut (
    .clk(clk), .reset(reset),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .rd_busy_a(rd_busy_a), .rd_busy_b(rd_busy_b),
    .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
    .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ok(rsv_ok),
    .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge, then let combinational outputs settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en0 = 1'b0; wr_en1 = 1'b0; rsv_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rd_addr_a = 5'd0; rd_addr_b = 5'd0;
    wr_addr0 = 5'd0; wr_addr1 = 5'd0; wr_data0 = 32'd0; wr_data1 = 32'd0;
    rsv_addr = 5'd0;
    idle();
    step();
    // Reset must win over a concurrent write and reservation.
    wr_en0 = 1'b1; wr_addr0 = 5'd5; wr_data0 = 32'hDEAD;
    rsv_en = 1'b1; rsv_addr = 5'd6;
    step();
    reset = 1'b0; idle();
    rd_addr_a = 5'd5; rd_addr_b = 5'd31;
    #1;
    check("t1_reg5", rd_data_a, 32'd500);
    check("t1_reg31", rd_data_b, 32'd3100);
    check("t1_busy_vec", busy_vec, 32'd0);
    check("t1_rd_busy_a", {31'd0, rd_busy_a}, 32'd0);
    rsv_en = 1'b1; rsv_addr = 5'd0;
    #1;
    check("t1_rsv_ok", {31'd0, rsv_ok}, 32'd1);
    rsv_en = 1'b0;
    #1;
    check("t1_rsv_ok_idle", {31'd0, rsv_ok}, 32'd0);

    // T2 write then read on port B
    wr_en0 = 1'b1; wr_addr0 = 5'd3; wr_data0 = 32'h3F800000; rd_addr_b = 5'd3;
    #1;
`ifdef RF_BYPASS_EN
    check("t2_same_cycle", rd_data_b, 32'h3F800000);
`else
    check("t2_same_cycle", rd_data_b, 32'd300);
`endif
    step();
    idle();
    #1;
    check("t2_next_cycle", rd_data_b, 32'h3F800000);

    // T3 dual write to one address: lane 1 wins, busy cleared
    rsv_en = 1'b1; rsv_addr = 5'd7;
    step();
    idle();
    check("t3_busy_set", busy_vec, 32'h0000_0080);
    wr_en0 = 1'b1; wr_addr0 = 5'd7; wr_data0 = 32'h11;
    wr_en1 = 1'b1; wr_addr1 = 5'd7; wr_data1 = 32'h22;
    step();
    idle();
    rd_addr_a = 5'd7;
    #1;
    check("t3_reg7", rd_data_a, 32'h22);
    check("t3_busy_clr", busy_vec, 32'd0);

    // Distinct-address dual write
    wr_en0 = 1'b1; wr_addr0 = 5'd10; wr_data0 = 32'hA0A0;
    wr_en1 = 1'b1; wr_addr1 = 5'd11; wr_data1 = 32'hB1B1;
    step();
    idle();
    rd_addr_a = 5'd10; rd_addr_b = 5'd11;
    #1;
    check("dual_reg10", rd_data_a, 32'hA0A0);
    check("dual_reg11", rd_data_b, 32'hB1B1);

    // T4 scoreboard reserve / WAW reject / writeback clear
    rsv_en = 1'b1; rsv_addr = 5'd9;
    #1;
    check("t4_rsv_ok", {31'd0, rsv_ok}, 32'd1);
    step();
    check("t4_busy9", busy_vec, 32'h0000_0200);
    rd_addr_a = 5'd9;
    #1;
    check("t4_rd_busy_a", {31'd0, rd_busy_a}, 32'd1);
    check("t4_rsv_reject", {31'd0, rsv_ok}, 32'd0);
    step();
    rsv_en = 1'b0;
    check("t4_busy_kept", busy_vec, 32'h0000_0200);
    wr_en1 = 1'b1; wr_addr1 = 5'd9; wr_data1 = 32'h99;
    step();
    idle();
    #1;
    check("t4_busy_clr", busy_vec, 32'd0);
    check("t4_reg9", rd_data_a, 32'h99);

    // T5 reservation colliding with a same-cycle clear
    rsv_en = 1'b1; rsv_addr = 5'd4;
    step();
    check("t5_busy4", busy_vec, 32'h0000_0010);
    wr_en0 = 1'b1; wr_addr0 = 5'd4; wr_data0 = 32'h44;
    #1;
    check("t5_rsv_collide", {31'd0, rsv_ok}, 32'd0);
    step();
    idle();
    check("t5_busy_after", busy_vec, 32'd0);
    rsv_en = 1'b1; rsv_addr = 5'd12;
    wr_en1 = 1'b1; wr_addr1 = 5'd12; wr_data1 = 32'hC;
    #1;
    check("t5_collide_idle_reg", {31'd0, rsv_ok}, 32'd0);
    step();
    idle();
    check("t5_no_set", busy_vec, 32'd0);

    // T6 forwarding (register 2 made busy first so the busy override is visible)
    rsv_en = 1'b1; rsv_addr = 5'd2;
    step();
    idle();
    rd_addr_a = 5'd2;
    wr_en0 = 1'b1; wr_addr0 = 5'd2; wr_data0 = 32'hAB;
    #1;
`ifdef RF_BYPASS_EN
    check("t6_data", rd_data_a, 32'hAB);
    check("t6_busy", {31'd0, rd_busy_a}, 32'd0);
`else
    check("t6_data", rd_data_a, 32'd200);
    check("t6_busy", {31'd0, rd_busy_a}, 32'd1);
`endif
    step();
    idle();
    #1;
    check("t6_after_data", rd_data_a, 32'hAB);
    check("t6_after_busy", {31'd0, rd_busy_a}, 32'd0);
    wr_en0 = 1'b1; wr_addr0 = 5'd2; wr_data0 = 32'h1;
    wr_en1 = 1'b1; wr_addr1 = 5'd2; wr_data1 = 32'h2;
    #1;
`ifdef RF_BYPASS_EN
    check("t6_lane1_prio", rd_data_a, 32'h2);
`else
    check("t6_lane1_prio", rd_data_a, 32'hAB);
`endif
    step();
    idle();
    #1;
    check("t6_commit", rd_data_a, 32'h2);

    // Re-reset restores initial contents and clears the scoreboard
    rsv_en = 1'b1; rsv_addr = 5'd20;
    step();
    idle();
    check("rr_busy_set", busy_vec, 32'h0010_0000);
    reset = 1'b1;
    step();
    reset = 1'b0;
    rd_addr_a = 5'd3; rd_addr_b = 5'd2;
    #1;
    check("rr_reg3", rd_data_a, 32'd300);
    check("rr_reg2", rd_data_b, 32'd200);
    check("rr_busy", busy_vec, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
